// File: rtl/branch_target_buffer_pkg.sv
// ---------------------------------------------------------------------------
// branch_target_buffer_pkg
//   Shared definitions for the branch target buffer:
//     - DEFAULT_ENTRY_BITS : log2 of the default table depth
//     - ctr_e              : 2-bit saturating direction counter encoding
//     - ctr_predicts_taken : the counter MSB is the taken/not-taken prediction
// ---------------------------------------------------------------------------
package branch_target_buffer_pkg;

  localparam int DEFAULT_ENTRY_BITS = 4;

  // Strongly/weakly not-taken, weakly/strongly taken.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic logic ctr_predicts_taken(input ctr_e ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// ---------------------------------------------------------------------------
// btb_sat_ctr
//   Next-state function of a 2-bit saturating branch direction counter.
//   Counts up towards ST on a taken outcome, down towards SNT otherwise,
//   and holds at either end.
//
// Ports
//   i_ctr      in   2  current counter value (ctr_e encoding)
//   i_taken    in   1  resolved branch outcome
//   o_next_ctr out  2  updated counter value
// ---------------------------------------------------------------------------
module btb_sat_ctr
  import branch_target_buffer_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_next_ctr
);

  always_comb begin
    // NOTE: assigning a default first gives every path a value, so no latch is inferred.
    o_next_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != ST) o_next_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != SNT) o_next_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//   Direct-mapped branch target buffer with 2-bit direction counters.
//   Fetch-stage lookup is purely combinational; the table is trained by the
//   execute stage when a conditional branch resolves. Also reports
//   mispredictions with the corrected fetch address and keeps branch and
//   misprediction statistics.
//
// Ports
//   clk            in   1   clock, all state changes on rising edge
//   rst            in   1   asynchronous active-high reset
//   PC_IF          in   32  fetch address to predict
//   taken_IF       out  1   1 = predicted taken
//   pred_target_IF out  32  predicted target, 0 when not predicted taken
//   bubbleE        in   1   execute stall, blocks all updates
//   br_EX          in   1   execute holds a resolved conditional branch
//   PC_EX          in   32  address of that branch
//   taken_EX       in   1   prediction that was made for it at fetch
//   br_taken_EX    in   1   actual outcome
//   br_target_EX   in   32  actual target
//   mispredict_EX  out  1   prediction differed from outcome
//   redirect_PC_EX out  32  correct next fetch address
//   br_cnt         out  32  resolved branch count (wraps)
//   miss_cnt       out  32  misprediction count (wraps)
// ---------------------------------------------------------------------------
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRY_BITS = DEFAULT_ENTRY_BITS
) (
  input  logic        clk,
  input  logic        rst,
  // fetch-stage lookup
  input  logic [31:0] PC_IF,
  output logic        taken_IF,
  output logic [31:0] pred_target_IF,
  // execute-stage resolution
  input  logic        bubbleE,
  input  logic        br_EX,
  input  logic [31:0] PC_EX,
  input  logic        taken_EX,
  input  logic        br_taken_EX,
  input  logic [31:0] br_target_EX,
  output logic        mispredict_EX,
  output logic [31:0] redirect_PC_EX,
  // statistics
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  localparam int NUM_ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W       = 32 - ENTRY_BITS - 2;

  // -------------------------------------------------------------------------
  // Table storage: flop arrays, read asynchronously from both stages.
  // -------------------------------------------------------------------------
  logic              r_valid  [NUM_ENTRIES];
  ctr_e              r_ctr    [NUM_ENTRIES];
  logic [TAG_W-1:0]  r_tag    [NUM_ENTRIES];
  logic [31:0]       r_target [NUM_ENTRIES];

  // -------------------------------------------------------------------------
  // Address decomposition. PC[1:0] never selects an entry or forms the tag.
  // -------------------------------------------------------------------------
  logic [ENTRY_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic [ENTRY_BITS-1:0] w_ex_idx;
  logic [TAG_W-1:0]      w_ex_tag;
  logic                  w_unused_pc_lsbs;

  assign w_if_idx         = PC_IF[ENTRY_BITS+1:2];
  assign w_if_tag         = PC_IF[31:ENTRY_BITS+2];
  assign w_ex_idx         = PC_EX[ENTRY_BITS+1:2];
  assign w_ex_tag         = PC_EX[31:ENTRY_BITS+2];
  assign w_unused_pc_lsbs = ^{PC_IF[1:0], PC_EX[1:0]};

  // -------------------------------------------------------------------------
  // Fetch lookup. Reads the registered table, so an update landing in the
  // same cycle is only seen from the following cycle on.
  // -------------------------------------------------------------------------
  logic w_if_hit;

  assign w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign taken_IF       = w_if_hit && ctr_predicts_taken(r_ctr[w_if_idx]);
  assign pred_target_IF = taken_IF ? r_target[w_if_idx] : 32'd0;

  // -------------------------------------------------------------------------
  // Execute resolution.
  // -------------------------------------------------------------------------
  logic       w_upd_en;
  logic       w_ex_hit;
  logic       w_alloc;
  logic [1:0] w_next_ctr;

  // A stalled execute stage re-presents the same branch next cycle, so it
  // must not train the table or the statistics until the stall clears.
  assign w_upd_en = br_EX && !bubbleE;
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  // Only taken branches earn an entry; a not-taken miss leaves the table alone.
  assign w_alloc  = w_upd_en && !w_ex_hit && br_taken_EX;

  assign mispredict_EX  = br_EX && (taken_EX != br_taken_EX);
  assign redirect_PC_EX = br_taken_EX ? br_target_EX : (PC_EX + 32'd4);

  btb_sat_ctr u_sat_ctr (
    .i_ctr      (r_ctr[w_ex_idx]),
    .i_taken    (br_taken_EX),
    .o_next_ctr (w_next_ctr)
  );

  // -------------------------------------------------------------------------
  // Valid bits and direction counters: these define what the predictor
  // says, so they are cleared by reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= WNT;
      end
    end else if (w_upd_en) begin
      // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
      if (w_ex_hit) begin
        r_ctr[w_ex_idx] <= ctr_e'(w_next_ctr);
      end else if (br_taken_EX) begin
        r_valid[w_ex_idx] <= 1'b1;
        r_ctr[w_ex_idx]   <= WT;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Tags and targets: payload only, meaningful solely behind a valid bit.
  // -------------------------------------------------------------------------
  // NOTE: the payload arrays carry no reset; the cleared valid bits already mask them.
  always_ff @(posedge clk) begin
    if (!rst && w_upd_en && br_taken_EX) begin
      // A taken hit refreshes the target; a taken miss claims the entry.
      r_target[w_ex_idx] <= br_target_EX;
      if (w_alloc) r_tag[w_ex_idx] <= w_ex_tag;
    end
  end

  // -------------------------------------------------------------------------
  // Statistics, free-running 32-bit counters that wrap.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt   <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (w_upd_en) begin
      br_cnt <= br_cnt + 32'd1;
      if (mispredict_EX) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer
//   Directed scenarios followed by randomized traffic, every output compared
//   against a table-level reference model of the predictor.
// ---------------------------------------------------------------------------
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_IF;
  logic        taken_IF;
  logic [31:0] pred_target_IF;
  logic        bubbleE;
  logic        br_EX;
  logic [31:0] PC_EX;
  logic        taken_EX;
  logic        br_taken_EX;
  logic [31:0] br_target_EX;
  logic        mispredict_EX;
  logic [31:0] redirect_PC_EX;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  always #5 clk = ~clk;

  branch_target_buffer #(.ENTRY_BITS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .PC_IF          (PC_IF),
    .taken_IF       (taken_IF),
    .pred_target_IF (pred_target_IF),
    .bubbleE        (bubbleE),
    .br_EX          (br_EX),
    .PC_EX          (PC_EX),
    .taken_EX       (taken_EX),
    .br_taken_EX    (br_taken_EX),
    .br_target_EX   (br_target_EX),
    .mispredict_EX  (mispredict_EX),
    .redirect_PC_EX (redirect_PC_EX),
    .br_cnt         (br_cnt),
    .miss_cnt       (miss_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: 16 entries, plain integers ------------
  typedef struct {
    bit          valid;
    int unsigned tag;
    int unsigned target;
    int          ctr;     // 0..3, predicts taken when >= 2
  } ent_t;

  ent_t        m_tab [16];
  int unsigned m_br;
  int unsigned m_miss;

  function automatic int unsigned m_idx(input int unsigned pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned m_tag(input int unsigned pc);
    return pc / 64;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_tab[i].valid  = 0;
      m_tab[i].ctr    = 1;
      m_tab[i].tag    = 0;
      m_tab[i].target = 0;
    end
    m_br   = 0;
    m_miss = 0;
  endtask

  task automatic model_lookup(input int unsigned pc, output bit tk, output int unsigned tgt);
    ent_t e;
    e   = m_tab[m_idx(pc)];
    tk  = e.valid && (e.tag == m_tag(pc)) && (e.ctr >= 2);
    tgt = tk ? e.target : 0;
  endtask

  task automatic model_update(input int unsigned pc, input bit pred, input bit tk,
                              input int unsigned tgt);
    int unsigned i;
    i = m_idx(pc);
    m_br++;
    if (pred != tk) m_miss++;
    if (m_tab[i].valid && m_tab[i].tag == m_tag(pc)) begin
      if (tk) begin
        m_tab[i].ctr    = (m_tab[i].ctr == 3) ? 3 : m_tab[i].ctr + 1;
        m_tab[i].target = tgt;
      end else begin
        m_tab[i].ctr = (m_tab[i].ctr == 0) ? 0 : m_tab[i].ctr - 1;
      end
    end else if (tk) begin
      m_tab[i].valid  = 1;
      m_tab[i].tag    = m_tag(pc);
      m_tab[i].target = tgt;
      m_tab[i].ctr    = 2;
    end
  endtask

  // ---------------- cycle helpers ----------------
  // drive(): called just after a rising edge; applies inputs and checks the
  // combinational outputs mid-cycle. commit(): trains the model, crosses the
  // edge and checks the statistics.
  logic        c_br, c_bub, c_tex, c_btk;
  logic [31:0] c_pc_ex, c_tgt;

  task automatic drive(input logic [31:0] pc_if, input logic br, input logic bub,
                       input logic [31:0] pc_ex, input logic tex, input logic btk,
                       input logic [31:0] tgt);
    bit          e_tk;
    int unsigned e_tgt;
    PC_IF = pc_if; br_EX = br; bubbleE = bub; PC_EX = pc_ex;
    taken_EX = tex; br_taken_EX = btk; br_target_EX = tgt;
    c_br = br; c_bub = bub; c_pc_ex = pc_ex; c_tex = tex; c_btk = btk; c_tgt = tgt;
    #3;
    model_lookup(pc_if, e_tk, e_tgt);
    check("taken_IF", {31'd0, taken_IF}, {31'd0, e_tk});
    check("pred_target_IF", pred_target_IF, e_tgt);
    check("mispredict_EX", {31'd0, mispredict_EX}, {31'd0, br && (tex != btk)});
    check("redirect_PC_EX", redirect_PC_EX, btk ? tgt : pc_ex + 32'd4);
  endtask

  task automatic commit();
    if (c_br && !c_bub) model_update(c_pc_ex, c_tex, c_btk, c_tgt);
    @(posedge clk);
    #1;
    check("br_cnt", br_cnt, m_br);
    check("miss_cnt", miss_cnt, m_miss);
  endtask

  task automatic idle(input logic [31:0] pc_if);
    drive(pc_if, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  int unsigned br_before;

  initial begin
    rst = 1'b1;
    PC_IF = 32'h100; br_EX = 1'b0; bubbleE = 1'b0; PC_EX = '0;
    taken_EX = 1'b0; br_taken_EX = 1'b0; br_target_EX = '0;
    model_reset();
    #2;
    check("rst_hold_taken", {31'd0, taken_IF}, 32'd0);
    check("rst_hold_target", pred_target_IF, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    idle(32'h100);
    check("reset_taken", {31'd0, taken_IF}, 32'd0);
    check("reset_br_cnt", br_cnt, 32'd0);
    commit();

    // First allocation; same-cycle lookup still sees the empty entry
    drive(32'h100, 1, 0, 32'h100, 0, 1, 32'h200);
    check("alloc_mispredict", {31'd0, mispredict_EX}, 32'd1);
    check("alloc_redirect", redirect_PC_EX, 32'h200);
    check("alloc_same_cycle", {31'd0, taken_IF}, 32'd0);
    commit();
    check("alloc_miss_cnt", miss_cnt, 32'd1);
    idle(32'h100);
    check("alloc_visible", {31'd0, taken_IF}, 32'd1);
    check("alloc_target", pred_target_IF, 32'h200);
    commit();

    // Two not-taken resolutions walk the counter 10 -> 01 -> 00
    drive(32'h100, 1, 0, 32'h100, 1, 0, 32'h200);
    check("nt1_redirect", redirect_PC_EX, 32'h104);
    commit();
    drive(32'h100, 1, 0, 32'h100, 0, 0, 32'h200);
    check("nt2_taken_IF", {31'd0, taken_IF}, 32'd0);
    check("nt2_redirect", redirect_PC_EX, 32'h104);
    commit();
    idle(32'h100);
    commit();

    // Rebuild to a taken prediction (00 -> 01 -> 10), then alias at 0x140
    drive(32'h100, 1, 0, 32'h100, 0, 1, 32'h200);
    commit();
    drive(32'h100, 1, 0, 32'h100, 0, 1, 32'h200);
    commit();
    idle(32'h100);
    check("rebuilt_taken", {31'd0, taken_IF}, 32'd1);
    commit();
    idle(32'h140);
    check("alias_lookup", {31'd0, taken_IF}, 32'd0);
    commit();
    drive(32'h100, 1, 0, 32'h140, 0, 1, 32'h300);
    commit();
    idle(32'h100);
    check("alias_evicted", {31'd0, taken_IF}, 32'd0);
    commit();
    idle(32'h140);
    check("alias_owner_target", pred_target_IF, 32'h300);
    commit();

    // Three stalled cycles then the stall drops: exactly one count
    br_before = m_br;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, 1, 1, 32'h80, 1, 0, 32'h0);
      commit();
    end
    drive(32'h0, 1, 0, 32'h80, 1, 0, 32'h0);
    commit();
    check("stall_single_count", br_cnt, br_before + 1);

    // Async reset pulse between clock edges
    idle(32'h140);
    check("pre_pulse_taken", {31'd0, taken_IF}, 32'd1);
    rst = 1'b1;
    #1;
    check("pulse_taken", {31'd0, taken_IF}, 32'd0);
    check("pulse_target", pred_target_IF, 32'd0);
    check("pulse_br_cnt", br_cnt, 32'd0);
    check("pulse_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;
    model_reset();
    c_br = 1'b0;
    commit();

    // Reset held across an update edge discards the update
    drive(32'h100, 1, 0, 32'h100, 0, 1, 32'h200);
    rst = 1'b1;
    c_br = 1'b0;
    commit();
    rst = 1'b0;
    model_reset();
    idle(32'h100);
    check("rst_update_dropped", {31'd0, taken_IF}, 32'd0);
    commit();

    // Randomized traffic over a small PC pool so hits, aliases and saturation occur
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc_a, pc_b, tgt;
      bit          tk_b;
      int unsigned tmp;
      pc_a = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom)};
      pc_b = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom)};
      if ($urandom_range(0, 3) == 0) pc_a = pc_b;
      tgt  = $urandom;
      model_lookup(pc_b, tk_b, tmp);
      drive(pc_a, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) == 0), pc_b,
            ($urandom_range(0, 4) == 0) ? ~tk_b : tk_b, 1'($urandom), tgt);
      commit();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
